// File: rtl/int_to_float_iter.sv
// Iterative integer (signed/unsigned, WIDTH bits) to IEEE-754 binary32 converter, all RISC-V rounding modes.
// Latency: accept edge + 3 clocks to out_valid; one operand in flight, 5-cycle throughput.
// Backpressure: result held in DONE until out_ready; in_ready low from accept until the cycle after the output handshake.
module int_to_float_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic             in_signed,
    input  logic [2:0]       in_rm,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_z,
    output logic             out_nx
);

    generate
        if (WIDTH < 32 || WIDTH > 64) begin : g_bad_width
            $error("int_to_float_iter: WIDTH must be in 32..64");
        end
    endgenerate

    localparam int         LZW     = $clog2(WIDTH) + 1;
    localparam logic [8:0] EXP_TOP = 9'(127 + WIDTH - 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ABS   = 3'd1;
    localparam logic [2:0] S_NORM  = 3'd2;
    localparam logic [2:0] S_ROUND = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    logic [2:0]       state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic             signed_q, signed_d;
    logic [2:0]       rm_q, rm_d;
    logic             sign_q, sign_d;
    logic [WIDTH-1:0] mag_q, mag_d;
    logic [LZW-1:0]   lzc_q, lzc_d;
    logic             zero_q, zero_d;
    logic [7:0]       exp_q, exp_d;
    logic [22:0]      man_q, man_d;
    logic             g_q, g_d;
    logic             s_q, s_d;
    logic [31:0]      z_q, z_d;
    logic             nx_q, nx_d;
    logic             valid_q, valid_d;

    logic [WIDTH-1:0] norm_shift;
    logic             round_inc;
    logic [23:0]      man_sum;
    logic [7:0]       exp_rnd;

    // Position of the leading one counted from the MSB; WIDTH when the value is zero.
    function automatic logic [LZW-1:0] f_lzc(input logic [WIDTH-1:0] v);
        logic [LZW-1:0] cnt;
        cnt = LZW'(WIDTH);
        for (int i = 0; i < WIDTH; i++) begin
            if (v[i]) begin
                cnt = LZW'(WIDTH - 1 - i);
            end
        end
        return cnt;
    endfunction

    assign norm_shift = mag_q << lzc_q;

    always_comb begin
        round_inc = 1'b0;
        case (rm_q)
            3'b001:  round_inc = 1'b0;
            3'b010:  round_inc = sign_q & (g_q | s_q);
            3'b011:  round_inc = ~sign_q & (g_q | s_q);
            3'b100:  round_inc = g_q;
            default: round_inc = g_q & (s_q | man_q[0]);
        endcase
    end

    // An all-ones mantissa wraps to zero on its own; only the exponent needs the carry.
    assign man_sum = {1'b0, man_q} + {23'd0, round_inc};
    assign exp_rnd = exp_q + {7'd0, man_sum[23]};

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        signed_d = signed_q;
        rm_d     = rm_q;
        sign_d   = sign_q;
        mag_d    = mag_q;
        lzc_d    = lzc_q;
        zero_d   = zero_q;
        exp_d    = exp_q;
        man_d    = man_q;
        g_d      = g_q;
        s_d      = s_q;
        z_d      = z_q;
        nx_d     = nx_q;
        valid_d  = valid_q;

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    a_d      = in_a;
                    signed_d = in_signed;
                    rm_d     = in_rm;
                    state_d  = S_ABS;
                end
            end
            S_ABS: begin
                sign_d  = signed_q & a_q[WIDTH-1];
                mag_d   = sign_d ? (~a_q + 1'b1) : a_q;
                lzc_d   = f_lzc(mag_d);
                state_d = S_NORM;
            end
            S_NORM: begin
                // A zero magnitude shifts out completely, so no leading one remains.
                zero_d  = ~norm_shift[WIDTH-1];
                man_d   = norm_shift[WIDTH-2 -: 23];
                g_d     = norm_shift[WIDTH-25];
                s_d     = |norm_shift[WIDTH-26:0];
                exp_d   = 8'(EXP_TOP - 9'(lzc_q));
                state_d = S_ROUND;
            end
            S_ROUND: begin
                if (zero_q) begin
                    z_d  = 32'd0;
                    nx_d = 1'b0;
                end else begin
                    z_d  = {sign_q, exp_rnd, man_sum[22:0]};
                    nx_d = g_q | s_q;
                end
                valid_d = 1'b1;
                state_d = S_DONE;
            end
            S_DONE: begin
                if (out_ready) begin
                    valid_d = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: begin
                valid_d = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            a_q      <= '0;
            signed_q <= 1'b0;
            rm_q     <= 3'd0;
            sign_q   <= 1'b0;
            mag_q    <= '0;
            lzc_q    <= '0;
            zero_q   <= 1'b0;
            exp_q    <= 8'd0;
            man_q    <= 23'd0;
            g_q      <= 1'b0;
            s_q      <= 1'b0;
            z_q      <= 32'd0;
            nx_q     <= 1'b0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            signed_q <= signed_d;
            rm_q     <= rm_d;
            sign_q   <= sign_d;
            mag_q    <= mag_d;
            lzc_q    <= lzc_d;
            zero_q   <= zero_d;
            exp_q    <= exp_d;
            man_q    <= man_d;
            g_q      <= g_d;
            s_q      <= s_d;
            z_q      <= z_d;
            nx_q     <= nx_d;
            valid_q  <= valid_d;
        end
    end

    assign in_ready  = rst & (state_q == S_IDLE);
    assign out_valid = valid_q;
    assign out_z     = z_q;
    assign out_nx    = nx_q;

endmodule

// File: tb/tb_int_to_float_iter.sv
// Directed bench for int_to_float_iter at WIDTH=32 and WIDTH=64: vector table plus backpressure and async-reset sequences.
module tb_int_to_float_iter;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic        v32 = 1'b0, r32, s32 = 1'b0, ov32, or32 = 1'b0, nx32;
    logic [31:0] a32 = '0, z32;
    logic [2:0]  rm32 = '0;

    logic        v64 = 1'b0, r64, s64 = 1'b0, ov64, or64 = 1'b0, nx64;
    logic [63:0] a64 = '0;
    logic [31:0] z64;
    logic [2:0]  rm64 = '0;

    int n_checks = 0;
    int n_errors = 0;

    int_to_float_iter #(.WIDTH(32)) u32 (
        .clk(clk), .rst(rst), .in_valid(v32), .in_ready(r32), .in_a(a32),
        .in_signed(s32), .in_rm(rm32), .out_valid(ov32), .out_ready(or32),
        .out_z(z32), .out_nx(nx32)
    );

    int_to_float_iter #(.WIDTH(64)) u64 (
        .clk(clk), .rst(rst), .in_valid(v64), .in_ready(r64), .in_a(a64),
        .in_signed(s64), .in_rm(rm64), .out_valid(ov64), .out_ready(or64),
        .out_z(z64), .out_nx(nx64)
    );

    typedef struct {
        logic        w64;
        logic [63:0] a;
        logic        sg;
        logic [2:0]  rm;
        logic [31:0] z;
        logic        nx;
    } vec_t;

    localparam int NV = 22;
    vec_t vecs[NV];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Drives one operand, waits for the result, returns it plus the clocks from accept to out_valid.
    task automatic convert(input logic w64, input logic [63:0] a, input logic sg, input logic [2:0] rm,
                           output logic [31:0] z, output logic nx, output int lat);
        int k;
        @(negedge clk);
        if (w64) begin a64 = a; s64 = sg; rm64 = rm; v64 = 1'b1; end
        else     begin a32 = a[31:0]; s32 = sg; rm32 = rm; v32 = 1'b1; end
        k = 0;
        while (!(w64 ? r64 : r32) && k < 20) begin
            @(negedge clk);
            k++;
        end
        @(negedge clk);
        v32 = 1'b0;
        v64 = 1'b0;
        lat = 0;
        while (!(w64 ? ov64 : ov32) && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        z  = w64 ? z64 : z32;
        nx = w64 ? nx64 : nx32;
        if (w64 ? ov64 : ov32) begin
            if (w64) or64 = 1'b1; else or32 = 1'b1;
            @(negedge clk);
            or32 = 1'b0;
            or64 = 1'b0;
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] z;
        logic        nx;
        int          lat;
        bit          saw;

        vecs[0]  = '{1'b0, 64'h2,                  1'b0, 3'd0, 32'h40000000, 1'b0};
        vecs[1]  = '{1'b0, 64'hFFFFFFF9,           1'b0, 3'd0, 32'h4F800000, 1'b1};
        vecs[2]  = '{1'b0, 64'hFFFFFFF9,           1'b0, 3'd1, 32'h4F7FFFFF, 1'b1};
        vecs[3]  = '{1'b0, 64'hFFFFFFF9,           1'b1, 3'd0, 32'hC0E00000, 1'b0};
        vecs[4]  = '{1'b0, 64'h01000001,           1'b0, 3'd0, 32'h4B800000, 1'b1};
        vecs[5]  = '{1'b0, 64'h01000001,           1'b0, 3'd3, 32'h4B800001, 1'b1};
        vecs[6]  = '{1'b0, 64'h01000003,           1'b0, 3'd0, 32'h4B800002, 1'b1};
        vecs[7]  = '{1'b0, 64'h01000001,           1'b0, 3'd4, 32'h4B800001, 1'b1};
        vecs[8]  = '{1'b0, 64'h0,                  1'b0, 3'd0, 32'h00000000, 1'b0};
        vecs[9]  = '{1'b0, 64'h0,                  1'b1, 3'd2, 32'h00000000, 1'b0};
        vecs[10] = '{1'b0, 64'h80000000,           1'b1, 3'd0, 32'hCF000000, 1'b0};
        vecs[11] = '{1'b0, 64'h80000000,           1'b0, 3'd0, 32'h4F000000, 1'b0};
        vecs[12] = '{1'b0, 64'h01000003,           1'b0, 3'd5, 32'h4B800002, 1'b1};
        vecs[13] = '{1'b0, 64'hFEFFFFFF,           1'b1, 3'd2, 32'hCB800001, 1'b1};
        vecs[14] = '{1'b0, 64'hFEFFFFFF,           1'b1, 3'd3, 32'hCB800000, 1'b1};
        vecs[15] = '{1'b0, 64'h01000001,           1'b0, 3'd2, 32'h4B800000, 1'b1};
        vecs[16] = '{1'b1, 64'hFFFFFFFFFFFFFFFF,   1'b0, 3'd0, 32'h5F800000, 1'b1};
        vecs[17] = '{1'b1, 64'hFFFFFFFFFFFFFFFF,   1'b1, 3'd2, 32'hBF800000, 1'b0};
        vecs[18] = '{1'b1, 64'h8000000000000000,   1'b1, 3'd1, 32'hDF000000, 1'b0};
        vecs[19] = '{1'b1, 64'h0000000100000001,   1'b0, 3'd3, 32'h4F800001, 1'b1};
        vecs[20] = '{1'b0, 64'hFFFFFFF9,           1'b0, 3'd2, 32'h4F7FFFFF, 1'b1};
        vecs[21] = '{1'b0, 64'h1,                  1'b0, 3'd1, 32'h3F800000, 1'b0};

        // Reset state
        repeat (3) @(negedge clk);
        check("reset in_ready32", r32, 0);
        check("reset in_ready64", r64, 0);
        check("reset out_valid32", ov32, 0);
        check("reset out_z32", z32, 0);
        check("reset out_nx32", nx32, 0);
        check("reset out_valid64", ov64, 0);
        rst = 1'b1;
        @(negedge clk);
        check("idle in_ready32", r32, 1);
        check("idle in_ready64", r64, 1);

        for (int i = 0; i < NV; i++) begin
            convert(vecs[i].w64, vecs[i].a, vecs[i].sg, vecs[i].rm, z, nx, lat);
            check($sformatf("vec%0d latency", i), lat, 3);
            check($sformatf("vec%0d out_z", i), z, vecs[i].z);
            check($sformatf("vec%0d out_nx", i), nx, vecs[i].nx);
        end

        // Backpressure: hold the result, offer a new operand meanwhile.
        @(negedge clk);
        a32 = 32'hFFFFFFF9; s32 = 1'b0; rm32 = 3'd0; v32 = 1'b1;
        @(negedge clk);
        v32 = 1'b0;
        lat = 0;
        while (!ov32 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check("bp latency", lat, 3);
        a32 = 32'h2; v32 = 1'b1;
        for (int c = 0; c < 10; c++) begin
            check($sformatf("bp%0d out_valid", c), ov32, 1);
            check($sformatf("bp%0d out_z", c), z32, 32'h4F800000);
            check($sformatf("bp%0d in_ready", c), r32, 0);
            @(negedge clk);
        end
        v32 = 1'b0;
        or32 = 1'b1;
        @(negedge clk);
        or32 = 1'b0;
        check("bp after hs out_valid", ov32, 0);
        check("bp after hs in_ready", r32, 1);
        check("bp after hs out_z kept", z32, 32'h4F800000);
        check("bp after hs out_nx kept", nx32, 1);
        saw = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (ov32) saw = 1'b1;
        end
        check("bp no second result", saw, 0);

        // Asynchronous reset while the operand sits in NORM.
        @(negedge clk);
        a32 = 32'h2; s32 = 1'b0; rm32 = 3'd0; v32 = 1'b1;
        @(negedge clk);
        v32 = 1'b0;
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check("arst out_valid", ov32, 0);
        check("arst in_ready", r32, 0);
        check("arst out_z cleared", z32, 0);
        @(negedge clk);
        rst = 1'b1;
        saw = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (ov32) saw = 1'b1;
        end
        check("post-reset no stale result", saw, 0);
        check("post-reset in_ready", r32, 1);
        convert(1'b0, 64'hFFFFFFF9, 1'b1, 3'd0, z, nx, lat);
        check("post-reset latency", lat, 3);
        check("post-reset out_z", z, 32'hC0E00000);
        check("post-reset out_nx", nx, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
